// File: rtl/dmem_port_arbiter_if.sv
// Shared DataMemory port bundle: pipeline MEM side,
// loader/debug side and the DataMemory side.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 9
);
  logic              p_req;
  logic              p_rw;
  logic              p_se;
  logic [1:0]        p_size;
  logic [ADDR_W-1:0] p_addr;
  logic [31:0]       p_wdata;
  logic [31:0]       p_rdata;
  logic              p_stall;

  logic              l_req;
  logic              l_rw;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_wdata;
  logic              l_gnt;
  logic              l_done;
  logic [31:0]       l_rdata;

  logic              m_enable;
  logic              m_rw;
  logic              m_se;
  logic [1:0]        m_size;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  modport slave (
    input  p_req, p_rw, p_se, p_size,
    input  p_addr, p_wdata,
    output p_rdata, p_stall,
    input  l_req, l_rw, l_addr, l_wdata,
    output l_gnt, l_done, l_rdata,
    output m_enable, m_rw, m_se, m_size,
    output m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output p_req, p_rw, p_se, p_size,
    output p_addr, p_wdata,
    input  p_rdata, p_stall,
    output l_req, l_rw, l_addr, l_wdata,
    input  l_gnt, l_done, l_rdata,
    input  m_enable, m_rw, m_se, m_size,
    input  m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// DataMemory port arbiter: pipeline owns the port,
// loader steals it for one cycle when idle or starved.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               reset,
  dmem_port_arbiter_if.slave bus
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    L_XFER = 2'd1,
    L_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  starve_cnt;
  logic        xfer;
  logic        grant;
  logic        done_q;
  logic [31:0] rdata_q;

  assign xfer  = (state == L_XFER);
  assign grant = bus.l_req &
                 (~bus.p_req | (starve_cnt == SMAX));

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state: one loader cycle, then a pipeline cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant) state_nxt = L_XFER;
      L_XFER:  state_nxt = L_DONE;
      L_DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // count denied loader cycles while the pipeline hogs the port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!bus.l_req) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant)
        starve_cnt <= '0;
      else if (starve_cnt != SMAX)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // loader completion pulse and read capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= xfer;
      if (xfer && !bus.l_rw)
        rdata_q <= bus.m_rdata;
    end
  end

  // port mux: pipeline fields unless the loader owns it
  always_comb begin
    bus.m_enable = bus.p_req;
    bus.m_rw     = bus.p_rw;
    bus.m_se     = bus.p_se;
    bus.m_size   = bus.p_size;
    bus.m_addr   = bus.p_addr;
    bus.m_wdata  = bus.p_wdata;
    if (xfer) begin
      bus.m_enable = 1'b1;
      bus.m_rw     = bus.l_rw;
      bus.m_se     = 1'b0;
      bus.m_size   = 2'b10;
      bus.m_addr   = {bus.l_addr[ADDR_W-1:2], 2'b00};
      bus.m_wdata  = bus.l_wdata;
    end
  end

  assign bus.l_gnt   = xfer;
  assign bus.p_stall = xfer & bus.p_req;
  assign bus.p_rdata = bus.m_rdata;
  assign bus.l_done  = done_q;
  assign bus.l_rdata = rdata_q;

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single DataMemory port between the pipeline MEM stage and a word-wide loader/debug port used to preload or dump data memory while the core runs. The pipeline owns the port by default. A loader transfer takes the port for exactly one cycle, either when the pipeline is idle or after a bounded starvation wait. While the loader holds the port, the pipeline is told to stall. The block sits between EXMEM_Stage/MEM-stage control and DataMemory.

## Interface

Parameters:
- ADDR_W, 9, memory address width
- STARVE_MAX, 4, number of consecutive denied loader cycles before the loader is force-granted (range 1–15)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- p_req  in  1  pipeline MEM access (MEM_Enable)
- p_rw  in  1  pipeline read(0)/write(1)
- p_se  in  1  pipeline sign-extend
- p_size  in  2  pipeline size: 00 byte, 01 half, 10 word
- p_addr  in  ADDR_W  pipeline address
- p_wdata  in  32  pipeline store data
- p_rdata  out  32  read data to pipeline
- p_stall  out  1  pipeline must hold its MEM access and freeze PC/IFID/IDEX/EXMEM
- l_req  in  1  loader request; held with its fields until l_done
- l_rw  in  1  loader read(0)/write(1)
- l_addr  in  ADDR_W  loader address
- l_wdata  in  32  loader write data
- l_gnt  out  1  loader owns the port this cycle
- l_done  out  1  one-cycle completion pulse
- l_rdata  out  32  registered loader read data
- m_enable, m_rw, m_se  out  1 each  DataMemory Enable/ReadWrite/SE
- m_size  out  2  DataMemory Size
- m_addr  out  ADDR_W  DataMemory Address
- m_wdata  out  32  DataMemory DataIn
- m_rdata  in  32  DataMemory DataOut (combinational read)

## Operation

- States:
  - IDLE: pipeline owns the port.
  - L_XFER: loader owns the port.
  - L_DONE: pipeline owns the port. This state guarantees the pipeline one cycle between loader transfers.
- Port muxing:
  - In IDLE and L_DONE, m_* = p_* combinationally.
  - In L_XFER, m_enable=1, m_rw=l_rw, m_se=0, m_size=10, m_addr={l_addr[ADDR_W-1:2],2'b00}, m_wdata=l_wdata.
- Transitions from IDLE, evaluated at each rising edge:
  - l_req=1 and p_req=0 → L_XFER.
  - l_req=1 and p_req=1 and starve_cnt==STARVE_MAX → L_XFER.
  - Otherwise stay in IDLE.
- L_XFER → L_DONE unconditionally. On that edge:
  - l_rdata captures m_rdata if l_rw=0.
  - l_done is set for one cycle (registered pulse, high throughout L_DONE).
- L_DONE → IDLE unconditionally. l_req is not sampled in L_DONE.
- starve_cnt:
  - 4-bit register.
  - In IDLE with l_req=1 and p_req=1, increments, saturating at STARVE_MAX.
  - Clears when entering L_XFER, and in any cycle with l_req=0.
- Combinational outputs:
  - l_gnt = (state==L_XFER).
  - p_stall = (state==L_XFER) & p_req.
  - p_rdata = m_rdata. It is valid for the pipeline only when p_stall=0.
- Loader requests are always word-sized. l_addr[1:0] is ignored.
- Withdrawing l_req before grant cancels the request: no transfer, no l_done. Withdrawing it during L_XFER has no effect; the transfer completes.
- Simultaneous requests: the pipeline wins unless the starvation threshold has been reached.

## Timing

- Reset values: state=IDLE, starve_cnt=0, l_done=0, l_rdata=0, l_gnt=0, p_stall=0. m_* track p_* immediately.
- Reset asserted during L_XFER:
  - The mux returns to pipeline fields asynchronously.
  - No l_done is produced; the loader write is not guaranteed.
  - The loader must re-request.
- Best-case loader latency: l_req sampled at edge k → l_gnt high in cycle k..k+1 → l_done high in cycle k+1..k+2.
- Worst-case loader latency: STARVE_MAX denied cycles plus the best case.
- Minimum loader issue period is 3 cycles (L_XFER, L_DONE, IDLE sample).
- p_stall lasts at most 1 cycle per loader transfer and never occurs on consecutive L_XFER cycles.
- Memory write commits on the rising edge ending the cycle in which m_enable=1 and m_rw=1.

## Test plan

1. Reset: hold reset=0 with random inputs → l_done=0, l_rdata=0, l_gnt=0, p_stall=0, and m_* equal p_*. Release reset → remains IDLE.
2. Loader write, idle pipeline:
   - Stimulus: p_req=0; l_req=1, l_rw=1, l_addr=0x010, l_wdata=0xDEADBEEF.
   - Next cycle: l_gnt=1, m_enable=1, m_rw=1, m_size=10, m_addr=0x010, m_wdata=0xDEADBEEF.
   - Following cycle: l_done=1 for exactly one cycle, p_stall never set.
3. Starvation:
   - Stimulus: p_req=1 continuously; loader read of 0x010 (contents 0xDEADBEEF).
   - Required: 4 denied cycles, grant in the 5th; p_stall=1 for exactly that one cycle; l_rdata=0xDEADBEEF with l_done.
4. Pipeline passthrough: p_req=1, p_rw=1, p_size=00, p_addr=0x00B, p_wdata=0x5A, l_req=0 → m_* equal p_* every cycle; l_gnt=0.
5. Alignment and withdrawal:
   - l_addr=0x013 → m_addr=0x010.
   - l_req raised and dropped after 2 denied cycles → no l_gnt, no l_done, starve_cnt back to 0.
6. Reset mid-transfer: assert reset during L_XFER → m_* switch to p_* within the same cycle; no l_done afterwards; starve_cnt=0.
